// File: rtl/scoreboard_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_scan_ctrl
// Brief    : Time-multiplexed scan controller for a 4-digit two-team score
//            display, with per-slot anode blanking and a once-per-frame score
//            snapshot. Optional macro: LEADING_ZERO_BLANK_EN blanks zero tens.
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] score_a,
    input  logic [7:0] score_b,
    output logic       sel_team,
    output logic       sel_digit,
    output logic [3:0] anode_n,
    output logic [6:0] seg_n,
    output logic       frame_tick
);

    localparam int               CNT_W       = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_blank_end = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_snap;
    logic [3:0]       r_anode_n;
    logic [6:0]       r_seg_n;
    logic             r_frame_tick;

    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_blank;
    logic [3:0]       w_nibble;
    logic [3:0]       w_anode_n;
    logic [6:0]       w_seg_n;

    assign w_slot_end  = (r_cnt == c_cnt_last);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);
    assign w_blank     = (r_cnt < c_blank_end);

    // Slot order: A tens, A units, B tens, B units
    always_comb begin
        w_nibble = 4'h0;
        case (r_idx)
            2'd0:    w_nibble = r_snap[15:12];
            2'd1:    w_nibble = r_snap[11:8];
            2'd2:    w_nibble = r_snap[7:4];
            default: w_nibble = r_snap[3:0];
        endcase
    end

    always_comb begin
        w_anode_n = 4'b1111;
        if (!w_blank) begin
            case (r_idx)
                2'd0:    w_anode_n = 4'b0111;
                2'd1:    w_anode_n = 4'b1011;
                2'd2:    w_anode_n = 4'b1101;
                default: w_anode_n = 4'b1110;
            endcase
        end
    end

    always_comb begin
        w_seg_n = 7'b1111111;
        case (w_nibble)
            4'd0:    w_seg_n = 7'b1000000;
            4'd1:    w_seg_n = 7'b1111001;
            4'd2:    w_seg_n = 7'b0100100;
            4'd3:    w_seg_n = 7'b0110000;
            4'd4:    w_seg_n = 7'b0011001;
            4'd5:    w_seg_n = 7'b0010010;
            4'd6:    w_seg_n = 7'b0000010;
            4'd7:    w_seg_n = 7'b1111000;
            4'd8:    w_seg_n = 7'b0000000;
            4'd9:    w_seg_n = 7'b0010000;
            default: w_seg_n = 7'b1111111;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (!r_idx[0] && (w_nibble == 4'd0)) begin
            w_seg_n = 7'b1111111;
        end
`endif
    end

    // Outputs lag the cnt/idx state by one clock; disable darkens the anodes
    // but keeps the last segment pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_snap       <= 16'h0000;
            r_anode_n    <= 4'b1111;
            r_seg_n      <= 7'b1111111;
            r_frame_tick <= 1'b0;
        end else if (enable) begin
            r_anode_n    <= w_anode_n;
            r_seg_n      <= w_seg_n;
            r_frame_tick <= w_frame_end;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_snap <= {score_a, score_b};
                end
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end else begin
            r_anode_n    <= 4'b1111;
            r_frame_tick <= 1'b0;
        end
    end

    assign sel_team   = r_idx[1];
    assign sel_digit  = r_idx[0];
    assign anode_n    = r_anode_n;
    assign seg_n      = r_seg_n;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard_scan_ctrl
// Brief    : Scoreboard bench for scoreboard_scan_ctrl (SCAN_DIV=4, BLANK_CYC=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_scoreboard_scan_ctrl;

    localparam int D = 4;
    localparam int B = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] score_a = 8'h00;
    logic [7:0] score_b = 8'h00;
    logic       sel_team;
    logic       sel_digit;
    logic [3:0] anode_n;
    logic [6:0] seg_n;
    logic       frame_tick;

    always #5 clk = ~clk;

    scoreboard_scan_ctrl #(.SCAN_DIV(D), .BLANK_CYC(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .score_a    (score_a),
        .score_b    (score_b),
        .sel_team   (sel_team),
        .sel_digit  (sel_digit),
        .anode_n    (anode_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
        logic       team;
        logic       dig;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: position in the scan is derived from the number of
    // enabled clock edges since reset; the display shows the frozen snapshot.
    int          n_en   = 0;
    logic [15:0] snap_m = 16'h0000;
    logic [6:0]  seg_m  = 7'h7f;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    logic [3:0] an_tbl [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model(input logic e, input logic [7:0] a, input logic [7:0] b);
        exp_t       x;
        int         pos;
        int         slot;
        int         d;
        logic [1:0] sl;
        pos    = n_en % D;
        slot   = (n_en / D) % 4;
        x.tick = 1'b0;
        if (e) begin
            x.an = (pos < B) ? 4'hF : an_tbl[slot];
            d    = int'((snap_m >> (4 * (3 - slot))) & 16'h000F);
            seg_m = (d > 9) ? 7'h7f : seg_tbl[d];
`ifdef LEADING_ZERO_BLANK_EN
            if ((slot % 2 == 0) && (d == 0)) seg_m = 7'h7f;
`endif
            if ((pos == D - 1) && (slot == 3)) begin
                x.tick = 1'b1;
                snap_m = {a, b};
            end
            n_en++;
        end else begin
            x.an = 4'hF;
        end
        x.seg  = seg_m;
        sl     = 2'((n_en / D) % 4);
        x.team = sl[1];
        x.dig  = sl[0];
        q.push_back(x);
    endtask

    task automatic step(input logic e, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        enable  = e;
        score_a = a;
        score_b = b;
        model(e, a, b);
    endtask

    task automatic check_reset_outputs();
        chk("rst_anode_n", 16'(anode_n), 16'h000F);
        chk("rst_seg_n", 16'(seg_n), 16'h007F);
        chk("rst_frame_tick", 16'(frame_tick), 16'h0000);
        chk("rst_sel", 16'({sel_team, sel_digit}), 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check_reset_outputs();
        n_en   = 0;
        snap_m = 16'h0000;
        seg_m  = 7'h7f;
        @(negedge clk);
        rst_n = 1'b1;
        model(1'b0, score_a, score_b);
    endtask

    function automatic logic [7:0] rand_score();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    // Monitor: compares every registered output update against the model
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("anode_n", 16'(anode_n), 16'(x.an));
                chk("seg_n", 16'(seg_n), 16'(x.seg));
                chk("frame_tick", 16'(frame_tick), 16'(x.tick));
                chk("sel_team", 16'(sel_team), 16'(x.team));
                chk("sel_digit", 16'(sel_digit), 16'(x.dig));
            end
        end
    end

    initial begin : driver
        logic [7:0] ra;
        logic [7:0] rb;
        score_a = 8'h12;
        score_b = 8'h34;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model(1'b0, score_a, score_b);

        // Frame 1 shows zeros, then the 12/34 snapshot; change A mid slot 1
        for (int i = 0; i < 21; i++) step(1'b1, 8'h12, 8'h34);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h57, 8'h34);
        // Freeze inside slot 2
        for (int i = 0; i < 10; i++) step(1'b0, 8'h57, 8'h34);
        for (int i = 0; i < 7; i++)  step(1'b1, 8'h57, 8'hA9);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h07, 8'hA9);
        for (int i = 0; i < 14; i++) step(1'b1, 8'h07, 8'hA9);
        // Reset in the middle of slot 3
        do_reset();

        for (int i = 0; i < 800; i++) begin
            ra = rand_score();
            rb = rand_score();
            step(($urandom_range(0, 9) != 0), ra, rb);
            if (i == 400) do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'h0000);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
